// File: rtl/gpr_wb_pkg.sv
// rtl/gpr_wb_pkg.sv - shared constants and types for the GPR write-back arbiter
package gpr_wb_pkg;

  localparam int XLEN   = 64;
  localparam int REG_AW = 5;
  localparam int NREG   = 2 ** REG_AW;

  typedef logic [REG_AW-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]   xlen_t;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LSU = 1'b1
  } wb_src_e;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-requester round-robin arbiter; bit 0 is ALU, bit 1 is LSU
module rr_arb2
  import gpr_wb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  wb_src_e ptr_q;
  wb_src_e ptr_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= SRC_ALU;
    end else begin
      ptr_q <= ptr_n;
    end
  end

  // The pointer only rotates on contention; a lone requester leaves it alone.
  always_comb begin
    gnt   = req;
    ptr_n = ptr_q;
    if (&req) begin
      gnt   = (ptr_q == SRC_ALU) ? 2'b01 : 2'b10;
      ptr_n = (ptr_q == SRC_ALU) ? SRC_LSU : SRC_ALU;
    end
  end

endmodule

// File: rtl/gpr_wb_arbiter.sv
// rtl/gpr_wb_arbiter.sv - merges ALU and LSU results onto the GPR write port and tracks pending writes
module gpr_wb_arbiter
  import gpr_wb_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            issue_vld,
  input  logic [REG_AW-1:0] issue_rd,
  input  logic            alu_vld,
  output logic            alu_rdy,
  input  logic [REG_AW-1:0] alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            lsu_vld,
  output logic            lsu_rdy,
  input  logic [REG_AW-1:0] lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  output logic [REG_AW-1:0] rd0_addr,
  output logic [XLEN-1:0] rd0_data,
  output logic            wr_en,
  output logic [NREG-1:0] busy
);

  logic [1:0]      req;
  logic [1:0]      gnt;
  logic            granted;
  reg_addr_t       g_rd;
  xlen_t           g_data;
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_n;

  assign req = {lsu_vld, alu_vld};

  rr_arb2 u_rr_arb2 (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .gnt   (gnt)
  );

  assign alu_rdy = gnt[0];
  assign lsu_rdy = gnt[1];
  assign granted = |gnt;
  assign g_rd    = gnt[1] ? lsu_rd : alu_rd;
  assign g_data  = gnt[1] ? lsu_data : alu_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd0_addr <= '0;
      rd0_data <= '0;
      wr_en    <= 1'b0;
    end else begin
      wr_en <= granted && (g_rd != '0);
      if (granted) begin
        rd0_addr <= g_rd;
        rd0_data <= g_data;
      end
    end
  end

  // Issue set is applied after the commit clear so a new producer wins the collision.
  always_comb begin
    busy_n = busy_q;
    if (wr_en) begin
      busy_n[rd0_addr] = 1'b0;
    end
    if (issue_vld && (issue_rd != '0)) begin
      busy_n[issue_rd] = 1'b1;
    end
    if (flush) begin
      busy_n = '0;
    end
    busy_n[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_n;
    end
  end

  assign busy = busy_q;

  a_alu_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (alu_vld && !alu_rdy) |=> (alu_vld && $stable(alu_rd) && $stable(alu_data)));

  a_lsu_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (lsu_vld && !lsu_rdy) |=> (lsu_vld && $stable(lsu_rd) && $stable(lsu_data)));

  a_rdy_needs_vld: assert property (@(posedge clk) disable iff (!rst_n)
    (!alu_rdy || alu_vld) && (!lsu_rdy || lsu_vld));

  a_no_waw: assert property (@(posedge clk) disable iff (!rst_n || flush)
    (issue_vld && (issue_rd != '0) && busy_q[issue_rd]) |-> (wr_en && (rd0_addr == issue_rd)));

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// tb/tb_gpr_wb_arbiter.sv - directed vector bench for gpr_wb_arbiter
module tb_gpr_wb_arbiter;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        issue_vld;
  logic [4:0]  issue_rd;
  logic        alu_vld;
  logic        alu_rdy;
  logic [4:0]  alu_rd;
  logic [63:0] alu_data;
  logic        lsu_vld;
  logic        lsu_rdy;
  logic [4:0]  lsu_rd;
  logic [63:0] lsu_data;
  logic [4:0]  rd0_addr;
  logic [63:0] rd0_data;
  logic        wr_en;
  logic [31:0] busy;

  int n_tests;
  int n_fail;

  gpr_wb_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .issue_vld (issue_vld),
    .issue_rd  (issue_rd),
    .alu_vld   (alu_vld),
    .alu_rdy   (alu_rdy),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .lsu_vld   (lsu_vld),
    .lsu_rdy   (lsu_rdy),
    .lsu_rd    (lsu_rd),
    .lsu_data  (lsu_data),
    .rd0_addr  (rd0_addr),
    .rd0_data  (rd0_data),
    .wr_en     (wr_en),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic        iv;
    logic [4:0]  ird;
    logic        av;
    logic [4:0]  ard;
    logic [63:0] ad;
    logic        lv;
    logic [4:0]  lrd;
    logic [63:0] ld;
    logic        e_ardy;
    logic        e_lrdy;
    logic        e_wr;
    logic [4:0]  e_addr;
    logic [63:0] e_data;
    logic [31:0] e_busy;
  } vec_t;

  vec_t tbl [14];

  function automatic vec_t mk(logic iv, logic [4:0] ird, logic av, logic [4:0] ard, logic [63:0] ad,
                              logic lv, logic [4:0] lrd, logic [63:0] ld, logic e_ardy, logic e_lrdy,
                              logic e_wr, logic [4:0] e_addr, logic [63:0] e_data, logic [31:0] e_busy);
    vec_t v;
    v.iv = iv; v.ird = ird; v.av = av; v.ard = ard; v.ad = ad;
    v.lv = lv; v.lrd = lrd; v.ld = ld;
    v.e_ardy = e_ardy; v.e_lrdy = e_lrdy; v.e_wr = e_wr;
    v.e_addr = e_addr; v.e_data = e_data; v.e_busy = e_busy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [4:0] ird, input logic av, input logic [4:0] ard,
                       input logic [63:0] ad, input logic lv, input logic [4:0] lrd, input logic [63:0] ld,
                       input logic fl);
    issue_vld = iv; issue_rd = ird;
    alu_vld = av; alu_rd = ard; alu_data = ad;
    lsu_vld = lv; lsu_rd = lrd; lsu_data = ld;
    flush = fl;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  localparam logic [63:0] DB = 64'hDEAD_BEEF_0000_0001;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Single ALU write, contention, then x0 suppression with an unrelated busy bit.
    tbl[0]  = mk(1, 5, 0, 0, 0,     0, 0, 0,     0, 0, 0, 0, 0,      32'h0);
    tbl[1]  = mk(0, 0, 0, 0, 0,     0, 0, 0,     0, 0, 0, 0, 0,      32'h20);
    tbl[2]  = mk(0, 0, 0, 0, 0,     0, 0, 0,     0, 0, 0, 0, 0,      32'h20);
    tbl[3]  = mk(0, 0, 1, 5, DB,    0, 0, 0,     1, 0, 0, 0, 0,      32'h20);
    tbl[4]  = mk(0, 0, 0, 0, 0,     0, 0, 0,     0, 0, 1, 5, DB,     32'h20);
    tbl[5]  = mk(0, 0, 0, 0, 0,     0, 0, 0,     0, 0, 0, 5, DB,     32'h0);
    tbl[6]  = mk(0, 0, 1, 1, 'h11,  1, 3, 'h33,  1, 0, 0, 5, DB,     32'h0);
    tbl[7]  = mk(0, 0, 1, 2, 'h22,  1, 3, 'h33,  0, 1, 1, 1, 'h11,   32'h0);
    tbl[8]  = mk(0, 0, 1, 2, 'h22,  1, 4, 'h44,  1, 0, 1, 3, 'h33,   32'h0);
    tbl[9]  = mk(0, 0, 1, 6, 'h66,  1, 4, 'h44,  0, 1, 1, 2, 'h22,   32'h0);
    tbl[10] = mk(0, 0, 1, 6, 'h66,  0, 0, 0,     1, 0, 1, 4, 'h44,   32'h0);
    tbl[11] = mk(1, 9, 0, 0, 0,     1, 0, ONES,  0, 1, 1, 6, 'h66,   32'h0);
    tbl[12] = mk(0, 0, 0, 0, 0,     0, 0, 0,     0, 0, 0, 0, ONES,   32'h200);
    tbl[13] = mk(0, 0, 0, 0, 0,     0, 0, 0,     0, 0, 0, 0, ONES,   32'h200);

    #2;
    chk("reset wr_en", {63'd0, wr_en}, 64'd0);
    chk("reset rd0_addr", {59'd0, rd0_addr}, 64'd0);
    chk("reset rd0_data", rd0_data, 64'd0);
    chk("reset busy", {32'd0, busy}, 64'd0);
    next_cycle();
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].iv, tbl[i].ird, tbl[i].av, tbl[i].ard, tbl[i].ad,
            tbl[i].lv, tbl[i].lrd, tbl[i].ld, 1'b0);
      @(negedge clk);
      chk($sformatf("row%0d alu_rdy", i), {63'd0, alu_rdy}, {63'd0, tbl[i].e_ardy});
      chk($sformatf("row%0d lsu_rdy", i), {63'd0, lsu_rdy}, {63'd0, tbl[i].e_lrdy});
      chk($sformatf("row%0d wr_en", i), {63'd0, wr_en}, {63'd0, tbl[i].e_wr});
      chk($sformatf("row%0d rd0_addr", i), {59'd0, rd0_addr}, {59'd0, tbl[i].e_addr});
      chk($sformatf("row%0d rd0_data", i), rd0_data, tbl[i].e_data);
      chk($sformatf("row%0d busy", i), {32'd0, busy}, {32'd0, tbl[i].e_busy});
      next_cycle();
    end

    // Set/clear collision on x7: re-issue while its write sits in the output register.
    drive(1, 7, 0, 0, 0, 0, 0, 0, 0);
    next_cycle();
    drive(0, 0, 1, 7, 'h77, 0, 0, 0, 0);
    next_cycle();
    drive(1, 7, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("coll wr_en", {63'd0, wr_en}, 64'd1);
    chk("coll rd0_addr", {59'd0, rd0_addr}, 64'd7);
    next_cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("coll busy7", {63'd0, busy[7]}, 64'd1);
    chk("coll busy", {32'd0, busy}, 64'h280);
    next_cycle();

    // Flush: clear, build busy=0xF0, then flush while the x4 write is in flight.
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    next_cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("flush1 busy", {32'd0, busy}, 64'd0);
    next_cycle();
    for (int r = 4; r < 8; r++) begin
      drive(1, 5'(r), 0, 0, 0, 0, 0, 0, 0);
      next_cycle();
    end
    drive(0, 0, 1, 4, 'h4444, 0, 0, 0, 0);
    @(negedge clk);
    chk("flush busy F0", {32'd0, busy}, 64'hF0);
    next_cycle();
    drive(1, 9, 0, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    chk("flush wr_en", {63'd0, wr_en}, 64'd1);
    chk("flush rd0_addr", {59'd0, rd0_addr}, 64'd4);
    chk("flush rd0_data", rd0_data, 64'h4444);
    next_cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("flush busy cleared", {32'd0, busy}, 64'd0);
    next_cycle();

    // Async reset while a write is pending, with the pointer left at LSU beforehand.
    drive(1, 3, 0, 0, 0, 0, 0, 0, 0);
    next_cycle();
    drive(0, 0, 1, 3, 'h3333, 1, 8, 'h8888, 0);
    @(negedge clk);
    chk("pre-rst alu_rdy", {63'd0, alu_rdy}, 64'd1);
    next_cycle();
    drive(0, 0, 0, 0, 0, 1, 8, 'h8888, 0);
    @(negedge clk);
    chk("pre-rst wr_en", {63'd0, wr_en}, 64'd1);
    chk("pre-rst busy", {32'd0, busy}, 64'h8);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async wr_en", {63'd0, wr_en}, 64'd0);
    chk("async busy", {32'd0, busy}, 64'd0);
    chk("async rd0_addr", {59'd0, rd0_addr}, 64'd0);
    chk("async rd0_data", rd0_data, 64'd0);
    next_cycle();
    rst_n = 1'b1;
    drive(0, 0, 1, 10, 'hAAAA, 1, 8, 'h8888, 0);
    @(negedge clk);
    chk("post-rst alu_rdy", {63'd0, alu_rdy}, 64'd1);
    chk("post-rst lsu_rdy", {63'd0, lsu_rdy}, 64'd0);
    next_cycle();
    drive(0, 0, 0, 0, 0, 1, 8, 'h8888, 0);
    @(negedge clk);
    chk("post-rst lsu_rdy2", {63'd0, lsu_rdy}, 64'd1);
    chk("post-rst rd0_addr", {59'd0, rd0_addr}, 64'd10);
    next_cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("post-rst lsu write", {59'd0, rd0_addr}, 64'd8);
    next_cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gpr_wb_arbiter.md
Name: gpr_wb_arbiter

Overview:
- Write-back stage directly upstream of the GPR file; owns the GPR's single write port (write address, write data, write enable).
- Merges two producer channels into that port: ALU result and LSU load data, both valid/ready.
- Keeps a 32-bit busy scoreboard so the issue logic can stall on RAW hazards.
- Drives the write enable low for x0, so x0 never reaches the RAM.

Parameters:
- XLEN, 64, data width of GPR write port and producer channels.
- REG_AW, 5, register address width.
- NREG, 32, number of architectural registers (2**REG_AW).

Ports:
- clk  in  1  core clock; GPR RAM writes on the same edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  sync pipeline flush; clears scoreboard.
- issue_vld  in  1  instruction with destination issued this cycle.
- issue_rd  in  REG_AW  destination of issued instruction.
- alu_vld  in  1  ALU result valid.
- alu_rdy  out  1  ALU result accepted this cycle.
- alu_rd  in  REG_AW  ALU destination.
- alu_data  in  XLEN  ALU result.
- lsu_vld  in  1  load data valid.
- lsu_rdy  out  1  load data accepted this cycle.
- lsu_rd  in  REG_AW  load destination.
- lsu_data  in  XLEN  load data.
- rd0_addr  out  REG_AW  GPR write address (registered).
- rd0_data  out  XLEN  GPR write data (registered); also the forwarding value.
- wr_en  out  1  GPR write enable (registered); feeds the GPR clk_en.
- busy  out  NREG  scoreboard; bit i=1 means a write to xi is pending.

Behaviour:
- Reset (async, rst_n=0): rd0_addr=0, rd0_data=0, wr_en=0, busy=0, round-robin pointer=ALU. All registers reset.
- Arbitration (combinational):
  - Single valid requester is granted.
  - Both valid: grant the source the round-robin pointer names.
  - After a both-valid grant, the pointer moves to the other source. The pointer is unchanged when only one source requests.
  - alu_rdy = alu grant; lsu_rdy = lsu grant. A ready is never high without its valid.
- Producers hold vld/rd/data stable until rdy=1 (protocol rule; checked by assertion).
- Output register, updated every edge:
  - rd0_addr/rd0_data take the granted rd/data.
  - wr_en = granted && rd!=0.
  - No grant gives wr_en=0; addr/data hold their last value.
- Latency:
  - Accept at edge N: the register shows the write during cycle N..N+1.
  - GPR RAM commits at edge N+1.
  - Throughput is one write per cycle; no bubbles between back-to-back accepts.
- x0 write: accepted (rdy=1), wr_en stays 0, busy unaffected.
- Scoreboard, at each edge:
  - Set bit issue_rd if issue_vld && issue_rd!=0.
  - Clear bit rd0_addr if wr_en=1, i.e. on the edge the RAM commits.
  - Same bit set and cleared on the same edge: set wins (new producer).
  - busy[0] is constant 0.
- Forwarding: while wr_en=1, a consumer reading rd0_addr uses rd0_data. The RAM is still stale in that cycle; busy is still 1 for that register.
- flush:
  - Clears busy to 0; flush beats a simultaneous issue set.
  - Does not cancel the write already in the output register (it still commits).
  - Does not gate arbitration.
- Reset mid-operation: any pending register write is dropped (wr_en=0 immediately, async). Producers must re-present.
- Assertions:
  - issue_vld to a register whose busy bit is already set, without a clearing write on the same edge, is illegal (WAW not supported).
  - rd0_data is 0-extended; no width conversion occurs (channel widths equal XLEN).

Decomposition:
- Package gpr_wb_pkg: XLEN, REG_AW, NREG constants; reg_addr_t, xlen_t typedefs; wb_src_e enum (SRC_ALU, SRC_LSU).
- One sub-module: rr_arb2, a two-requester round-robin arbiter (req[1:0], gnt[1:0], pointer flop, async active-low reset).
- Scoreboard and output register stay in gpr_wb_arbiter.

Test Plan:
- Single ALU write: issue x5 at cycle 0; ALU alu_rd=5, alu_data=0xDEAD_BEEF_0000_0001 at cycle 3 -> alu_rdy=1 at cycle 3; wr_en=1, rd0_addr=5 at cycle 4; busy[5] 1 from cycle 1 through cycle 4, 0 from cycle 5.
- Contention: both valid for 4 cycles (alu x1/x2, lsu x3/x4) after reset -> grants ALU, LSU, ALU, LSU; writes x1, x3, x2, x4 on consecutive cycles; no idle cycle.
- x0 suppression: lsu_rd=0, lsu_data=all-ones -> lsu_rdy=1, wr_en stays 0, busy unchanged.
- Set/clear collision: x7 write in output register while issue_rd=7 in the same cycle -> busy[7] remains 1 after the edge.
- Flush: busy=0x0000_00F0, flush with issue_rd=9 and pending write x4 -> busy=0 next cycle; x4 write still commits (wr_en=1, rd0_addr=4).
- Async reset: assert rst_n=0 mid-cycle while wr_en=1 -> wr_en, busy, rd0_addr, rd0_data go 0 without a clock edge; after release, the first contested grant goes to ALU.
